// File: rtl/drop_tick_scheduler.sv
// drop_tick_scheduler
// -------------------
// Gravity tick generator for the falling piece. A free-running counter
// measures an effective period derived from the current level (clamped to
// a floor) or from the fast-drop button, then raises a tick request that is
// held until the game-logic FSM acknowledges it. Supports pause, restart on
// new-piece spawn and an optional soft-drop row counter.
//
// Optional feature macro: DROP_SOFT_SCORE_EN
//   defined   -> o_soft_rows counts accepted fast ticks, saturating at 255
//   undefined -> o_soft_rows is tied to 8'd0
//
// Ports
//   i_clk        system clock, all logic on posedge
//   i_rst        synchronous active-high reset
//   i_enable     game running; low forces IDLE
//   i_pause      freezes counting; masks a pending request
//   i_restart    one-cycle pulse on new-piece spawn; restarts the period
//   i_level      current level 0..15
//   i_fast_in    debounced fast-drop button
//   i_drop_ack   game logic accepted the tick
//   o_drop_req   tick pending, held until acknowledged
//   o_drop_fast  value of i_fast_in captured when o_drop_req rose
//   o_soft_rows  soft-drop row count (0 unless DROP_SOFT_SCORE_EN)

module drop_tick_scheduler #(
    parameter int                CNT_W       = 24,
    parameter logic [CNT_W-1:0]  BASE_PERIOD = 24'd5_000_000,
    parameter logic [CNT_W-1:0]  LEVEL_STEP  = 24'd300_000,
    parameter logic [CNT_W-1:0]  MIN_PERIOD  = 24'd500_000,
    parameter logic [CNT_W-1:0]  FAST_PERIOD = 24'd250_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_pause,
    input  logic        i_restart,
    input  logic [3:0]  i_level,
    input  logic        i_fast_in,
    input  logic        i_drop_ack,
    output logic        o_drop_req,
    output logic        o_drop_fast,
    output logic [7:0]  o_soft_rows
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    // Level-derived period; negative or too-small results clamp to the floor.
    function automatic logic [CNT_W-1:0] sat_period(input logic signed [CNT_W+4:0] diff);
        if (diff < $signed({5'd0, MIN_PERIOD}))
            return MIN_PERIOD;
        else
            return diff[CNT_W-1:0];
    endfunction

    // Terminal count for a period; periods of 0 or 1 behave as 1.
    function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] period);
        if (period <= CNT_W'(1))
            return '0;
        else
            return period - CNT_W'(1);
    endfunction

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_drop_req;
    logic                   r_drop_fast;

    logic [CNT_W+3:0]       w_prod;
    logic signed [CNT_W+4:0] w_diff;
    logic [CNT_W-1:0]       w_lvl_p;
    logic [CNT_W-1:0]       w_eff;
    logic [CNT_W-1:0]       w_last;
    logic                   w_fire;
    logic                   w_accept;

    // Effective period, re-evaluated every cycle so level or button changes
    // take effect mid-count.
    assign w_prod   = {{CNT_W{1'b0}}, i_level} * {4'd0, LEVEL_STEP};
    assign w_diff   = $signed({5'd0, BASE_PERIOD}) - $signed({1'b0, w_prod});
    assign w_lvl_p  = sat_period(w_diff);
    assign w_eff    = (i_fast_in && (FAST_PERIOD < w_lvl_p)) ? FAST_PERIOD : w_lvl_p;
    assign w_last   = last_count(w_eff);

    // >= rather than == so a period that shrinks below the current count
    // fires immediately instead of wrapping.
    assign w_fire   = (r_cnt >= w_last);

    // A request is accepted only on a normal-priority edge in REQ.
    assign w_accept = (r_state == S_REQ) && r_drop_req && i_drop_ack &&
                      i_enable && !i_restart && !i_pause;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_drop_req  <= 1'b0;
            r_drop_fast <= 1'b0;
        end else if (!i_enable) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_drop_req <= 1'b0;
        end else if (i_restart) begin
            // New piece: cancel any pending tick and start a fresh period.
            r_state    <= S_COUNT;
            r_cnt      <= '0;
            r_drop_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_COUNT;
                    r_cnt   <= '0;
                end
                S_COUNT: begin
                    if (!i_pause) begin
                        if (w_fire) begin
                            r_state     <= S_REQ;
                            r_drop_req  <= 1'b1;
                            r_drop_fast <= i_fast_in;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_REQ: begin
                    // Pause masks the request; it comes back on the first
                    // unpaused edge. Ticks never accumulate while waiting.
                    if (i_pause) begin
                        r_drop_req <= 1'b0;
                    end else if (w_accept) begin
                        r_state    <= S_COUNT;
                        r_drop_req <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        r_drop_req <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_drop_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_drop_req  = r_drop_req;
    assign o_drop_fast = r_drop_fast;

`ifdef DROP_SOFT_SCORE_EN
    logic [7:0] r_soft_rows;

    // Counts rows dropped under the fast button; survives disable, clears on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_soft_rows <= 8'd0;
        end else if (w_accept && r_drop_fast && (r_soft_rows != 8'hFF)) begin
            r_soft_rows <= r_soft_rows + 8'd1;
        end
    end

    assign o_soft_rows = r_soft_rows;
`else
    assign o_soft_rows = 8'd0;
`endif

endmodule

// File: tb/tb_drop_tick_scheduler.sv
module tb_drop_tick_scheduler;

    localparam int BASE  = 100;
    localparam int STEP  = 10;
    localparam int MINP  = 20;
    localparam int FASTP = 5;

`ifdef DROP_SOFT_SCORE_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pause = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] level = 4'd0;
    logic       fast_in = 1'b0;
    logic       drop_ack = 1'b0;
    logic       drop_req;
    logic       drop_fast;
    logic [7:0] soft_rows;

    always #5 clk = ~clk;

    drop_tick_scheduler #(
        .CNT_W       (24),
        .BASE_PERIOD (24'd100),
        .LEVEL_STEP  (24'd10),
        .MIN_PERIOD  (24'd20),
        .FAST_PERIOD (24'd5)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_pause     (pause),
        .i_restart   (restart),
        .i_level     (level),
        .i_fast_in   (fast_in),
        .i_drop_ack  (drop_ack),
        .o_drop_req  (drop_req),
        .o_drop_fast (drop_fast),
        .o_soft_rows (soft_rows)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // Tick period in cycles straight from the level/button rules.
    function automatic int eff_period(input int lvl, input bit f);
        int p;
        p = BASE - lvl * STEP;
        if (p < MINP) p = MINP;
        if (f && FASTP < p) p = FASTP;
        if (p < 1) p = 1;
        return p;
    endfunction

    // m_mode: 0 idle, 1 waiting out a period, 2 tick outstanding
    int m_mode  = 0;
    int m_waited = 0;   // edges already spent in the current period
    bit m_req   = 1'b0;
    bit m_fast  = 1'b0;
    int m_soft  = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= 0; m_waited <= 0; m_req <= 1'b0; m_fast <= 1'b0;
            m_soft <= 0; m_valid <= 1'b1;
        end else if (m_valid) begin
            if (!enable) begin
                m_mode <= 0; m_waited <= 0; m_req <= 1'b0;
            end else if (restart) begin
                m_mode <= 1; m_waited <= 0; m_req <= 1'b0;
            end else if (m_mode == 0) begin
                m_mode <= 1; m_waited <= 0;
            end else if (m_mode == 1) begin
                if (!pause) begin
                    if (m_waited + 1 >= eff_period(int'(level), fast_in)) begin
                        m_mode <= 2; m_req <= 1'b1; m_fast <= fast_in; m_waited <= 0;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
            end else begin
                if (pause) begin
                    m_req <= 1'b0;
                end else if (m_req && drop_ack) begin
                    m_mode <= 1; m_waited <= 0; m_req <= 1'b0;
                    if (m_fast && m_soft < 255) m_soft <= m_soft + 1;
                end else begin
                    m_req <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("drop_req",  32'(drop_req),  32'(m_req));
            check("drop_fast", 32'(drop_fast), 32'(m_fast));
            check("soft_rows", 32'(soft_rows), SOFT_EN ? 32'(m_soft) : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until drop_req is seen high; -1 if the budget runs out.
    task automatic wait_rise(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (drop_req) return;
        end
        edges = -1;
    endtask

    int e;
    int highs;
    int timeouts;
    logic [7:0] soft_before;

    initial begin
        tick(3);
        check("reset_req",  32'(drop_req),  32'd0);
        check("reset_fast", 32'(drop_fast), 32'd0);
        check("reset_soft", 32'(soft_rows), 32'd0);
        rst = 1'b0;
        tick(2);
        check("idle_no_req", 32'(drop_req), 32'd0);

        // Level 0, ack held high
        enable = 1'b1; drop_ack = 1'b1; level = 4'd0;
        tick(1);
        wait_rise(200, e); check("first_rise_lvl0", e, 100);
        wait_rise(200, e); check("spacing_lvl0", e, 101);
        tick(1);           check("pulse_width_1", 32'(drop_req), 32'd0);

        // Level 3, then level 12 (clamped to floor)
        level = 4'd3;
        wait_rise(200, e); check("period_lvl3", e, 70);
        wait_rise(200, e); check("spacing_lvl3", e, 71);
        tick(1);
        level = 4'd12;
        wait_rise(200, e); check("period_lvl12_clamp", e, 20);
        wait_rise(200, e); check("spacing_lvl12", e, 21);

        // Level jump 0 -> 12 with count at 50 fires on the next edge
        tick(1);
        level = 4'd0;
        tick(50);
        level = 4'd12;
        wait_rise(5, e);   check("shrink_fires_next", e, 1);

        // Fast drop, ack withheld for 40 cycles
        tick(1);
        level = 4'd0; fast_in = 1'b1; drop_ack = 1'b0;
        wait_rise(50, e);  check("fast_period", e, 5);
        check("fast_flag", 32'(drop_fast), 32'd1);
        highs = 1;
        for (int i = 0; i < 39; i++) begin
            tick(1);
            if (drop_req) highs++;
        end
        check("held_40", highs, 40);
        drop_ack = 1'b1;
        tick(1);
        drop_ack = 1'b0;
        check("ack_drops_req", 32'(drop_req), 32'd0);
        wait_rise(50, e);  check("fast_after_ack", e, 5);
        check("fast_flag2", 32'(drop_fast), 32'd1);

        // Pause during count
        fast_in = 1'b0; drop_ack = 1'b1;
        tick(1);
        tick(60);
        pause = 1'b1;
        tick(30);
        pause = 1'b0;
        wait_rise(200, e); check("pause_resume", e, 40);

        // Pause while a tick is pending
        drop_ack = 1'b0; pause = 1'b1;
        tick(1);           check("pause_masks_req", 32'(drop_req), 32'd0);
        drop_ack = 1'b1;
        tick(3);           check("pause_ignores_ack", 32'(drop_req), 32'd0);
        drop_ack = 1'b0; pause = 1'b0;
        tick(1);           check("unpause_reasserts", 32'(drop_req), 32'd1);

        // restart and ack on the same edge: restart wins
        soft_before = soft_rows;
        drop_ack = 1'b1; restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("restart_drops_req", 32'(drop_req), 32'd0);
        check("restart_soft_same", 32'(soft_rows), 32'(soft_before));
        wait_rise(200, e); check("restart_period", e, 100);

        // 300 accepted fast ticks
        fast_in = 1'b1;
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            wait_rise(20, e);
            if (e < 0) timeouts++;
        end
        check("fast_tick_timeouts", timeouts, 0);
        tick(1);
        check("soft_saturate", 32'(soft_rows), SOFT_EN ? 32'd255 : 32'd0);

        // Reset mid-count clears everything
        tick(2);
        rst = 1'b1;
        tick(1);
        check("rst_req",  32'(drop_req),  32'd0);
        check("rst_fast", 32'(drop_fast), 32'd0);
        check("rst_soft", 32'(soft_rows), 32'd0);
        rst = 1'b0;
        fast_in = 1'b0;

        // Disable while a tick is pending
        wait_rise(200, e); check("rise_before_disable", e, 101);
        drop_ack = 1'b0; enable = 1'b0;
        tick(1);           check("disable_drops_req", 32'(drop_req), 32'd0);
        tick(3);           check("disabled_stays_low", 32'(drop_req), 32'd0);
        enable = 1'b1; drop_ack = 1'b1;
        tick(1);
        wait_rise(200, e); check("reenable_period", e, 100);

        // Randomized traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            enable   = ($urandom_range(0, 99) != 0);
            restart  = ($urandom_range(0, 59) == 0);
            pause    = ($urandom_range(0, 9) == 0);
            fast_in  = ($urandom_range(0, 3) == 0);
            drop_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
